// File: rtl/reg_file_ctx_pkg.sv
// Shared types for the register file: sequencer states, pair-op encoding and pair index helper.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_t;

  typedef logic [1:0] pair_op_t;

  localparam pair_op_t POP_NONE = 2'd0;
  localparam pair_op_t POP_ADD  = 2'd1;
  localparam pair_op_t POP_SUB  = 2'd2;
  localparam pair_op_t POP_MOVE = 2'd3;

  // Move outranks add/sub; add and sub together cancel out.
  function automatic pair_op_t pair_op_decode(input logic mv, input logic add, input logic sub);
    if (mv)          return POP_MOVE;
    if (add && !sub) return POP_ADD;
    if (sub && !add) return POP_SUB;
    return POP_NONE;
  endfunction

  function automatic int pair_lo_idx(input int sel);
    return sel & ~1;
  endfunction

endpackage

// File: rtl/reg_file_ctx_if.sv
// Memory-side handshake used by the context save/restore sequencer.
interface reg_file_ctx_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) ();
  logic              mem_req;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/reg_file_ctx_sequencer.sv
// Context spill/fill FSM: walks idx 0..NUM_REGS-1 over req/ack, one register per ack.
// Restore data is handed to the parent as a write strobe/index/data triple.
module ctx_sequencer
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctx_save_i,
  input  logic              ctx_restore_i,
  output logic              ctx_busy_o,
  output logic              ctx_done_o,
  input  logic [DATA_W-1:0] save_dat_i,
  output logic              rf_we_o,
  output logic [SEL_W-1:0]  rf_idx_o,
  output logic [DATA_W-1:0] rf_dat_o,
  reg_file_ctx_if.master    mem
);

  ctx_state_t       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    rf_we_o     = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (ctx_save_i)         state_d = SAVE;
        else if (ctx_restore_i) state_d = RESTORE;
      end
      SAVE, RESTORE: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (state_q == SAVE);
        if (mem.mem_ack) begin
          rf_we_o = (state_q == RESTORE);
          idx_d   = idx_q + SEL_W'(1);
          if (idx_q == SEL_W'(NUM_REGS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_addr  = idx_q;
  assign mem.mem_wdata = save_dat_i;
  assign rf_idx_o      = idx_q;
  assign rf_dat_o      = mem.mem_rdata;
  assign ctx_busy_o    = (state_q != IDLE);
  assign ctx_done_o    = done_q;

endmodule

// File: rtl/reg_file_ctx.sv
// Register file with pair pointer ops (add/sub/move) and a context save/restore sequencer.
// Optional REGFILE_ZERO_REG_EN: r0 reads as zero and discards every write.
module reg_file_ctx
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int CONST_W  = 8,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  din,
  input  logic [SEL_W-1:0]   a_sel,
  input  logic [SEL_W-1:0]   b_sel,
  input  logic               write_en,
  input  logic               pair_add,
  input  logic               pair_sub,
  input  logic               pair_move,
  input  logic [CONST_W-1:0] constant,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [DATA_W-1:0]  out_c,
  output logic               pair_cy,
  input  logic               ctx_save,
  input  logic               ctx_restore,
  output logic               ctx_busy,
  output logic               ctx_done,
  reg_file_ctx_if.master     mem
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic              cy_q, cy_d;

  logic              seq_we;
  logic [SEL_W-1:0]  seq_idx;
  logic [DATA_W-1:0] seq_dat;

  ctx_sequencer #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_seq (
    .clk           (clk),
    .reset         (reset),
    .ctx_save_i    (ctx_save),
    .ctx_restore_i (ctx_restore),
    .ctx_busy_o    (ctx_busy),
    .ctx_done_o    (ctx_done),
    .save_dat_i    (rf_q[seq_idx]),
    .rf_we_o       (seq_we),
    .rf_idx_o      (seq_idx),
    .rf_dat_o      (seq_dat),
    .mem           (mem)
  );

  pair_op_t         op;
  logic [SEL_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic             same_pair;
  logic [PW:0]      pair_cur, pair_res, offset;

  always_comb begin
    rf_d      = rf_q;
    cy_d      = cy_q;
    op        = pair_op_decode(pair_move, pair_add, pair_sub);
    a_lo      = SEL_W'(pair_lo_idx(int'(a_sel)));
    b_lo      = SEL_W'(pair_lo_idx(int'(b_sel)));
    a_hi      = {a_lo[SEL_W-1:1], 1'b1};
    b_hi      = {b_lo[SEL_W-1:1], 1'b1};
    same_pair = (a_lo == b_lo);
    offset    = (PW + 1)'(constant);
    pair_cur  = {1'b0, rf_q[b_hi], rf_q[b_lo]};
    pair_res  = (op == POP_SUB) ? (pair_cur - offset) : (pair_cur + offset);

    if (seq_we) begin
      rf_d[seq_idx] = seq_dat;
    end else if (!ctx_busy) begin
      if (op == POP_MOVE) begin
        if (!b_sel[0] && !same_pair) begin
          rf_d[b_lo] = rf_q[a_lo];
          rf_d[b_hi] = rf_q[a_hi];
        end
      end else begin
        // A register write into the target pair beats the pair update.
        if ((op == POP_ADD || op == POP_SUB) && !b_sel[0] && !(write_en && same_pair)) begin
          rf_d[b_lo] = pair_res[DATA_W-1:0];
          rf_d[b_hi] = pair_res[PW-1:DATA_W];
          cy_d       = pair_res[PW];
        end
        if (write_en) rf_d[a_sel] = din;
      end
    end
`ifdef REGFILE_ZERO_REG_EN
    rf_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q <= '{default: '0};
      cy_q <= 1'b0;
    end else begin
      rf_q <= rf_d;
      cy_q <= cy_d;
    end
  end

  assign out_a   = rf_q[a_sel];
  assign out_b   = rf_q[b_sel];
  assign out_c   = rf_q[{b_sel[SEL_W-1:1], 1'b1}];
  assign pair_cy = cy_q;

endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed bench for reg_file_ctx (default build, r0 ordinary register).
module tb_reg_file_ctx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [3:0] a_sel, b_sel;
  logic       write_en, pair_add, pair_sub, pair_move;
  logic [7:0] constant;
  logic [7:0] out_a, out_b, out_c;
  logic       pair_cy;
  logic       ctx_save, ctx_restore, ctx_busy, ctx_done;

  int checks   = 0;
  int failures = 0;

  reg_file_ctx_if #(.DATA_W(8), .SEL_W(4)) mem_if ();

  reg_file_ctx #(.DATA_W(8), .NUM_REGS(16), .CONST_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .write_en    (write_en),
    .pair_add    (pair_add),
    .pair_sub    (pair_sub),
    .pair_move   (pair_move),
    .constant    (constant),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .pair_cy     (pair_cy),
    .ctx_save    (ctx_save),
    .ctx_restore (ctx_restore),
    .ctx_busy    (ctx_busy),
    .ctx_done    (ctx_done),
    .mem         (mem_if)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] val);
    a_sel = idx; din = val; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = '0; a_sel = '0; b_sel = '0; constant = '0;
    write_en = 1'b0; pair_add = 1'b0; pair_sub = 1'b0; pair_move = 1'b0;
    ctx_save = 1'b0; ctx_restore = 1'b0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_a", out_a, 0);
    chk("rst_cy", pair_cy, 0);
    chk("rst_busy", ctx_busy, 0);
    chk("rst_done", ctx_done, 0);
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_we", mem_if.mem_we, 0);
    chk("rst_addr", mem_if.mem_addr, 0);

    // Pair add without and with carry-out.
    wr(4'd3, 8'h12); wr(4'd2, 8'hFF);
    b_sel = 4'd2; constant = 8'h01; pair_add = 1'b1; tick(); pair_add = 1'b0;
    chk("add_lo", out_b, 8'h00); chk("add_hi", out_c, 8'h13); chk("add_cy", pair_cy, 0);
    wr(4'd3, 8'hFF); wr(4'd2, 8'hFF);
    pair_add = 1'b1; tick(); pair_add = 1'b0;
    chk("addw_lo", out_b, 8'h00); chk("addw_hi", out_c, 8'h00); chk("addw_cy", pair_cy, 1);

    // Pair subtract with borrow, then ignored ops keep pair and carry.
    b_sel = 4'd4; pair_sub = 1'b1; tick(); pair_sub = 1'b0;
    chk("sub_lo", out_b, 8'hFF); chk("sub_hi", out_c, 8'hFF); chk("sub_cy", pair_cy, 1);
    b_sel = 4'd5; constant = 8'h01; pair_add = 1'b1; tick(); pair_add = 1'b0;
    chk("odd_b", out_b, 8'hFF); chk("odd_c", out_c, 8'hFF);
    b_sel = 4'd4; pair_add = 1'b1; pair_sub = 1'b1; tick(); pair_add = 1'b0; pair_sub = 1'b0;
    chk("both_lo", out_b, 8'hFF); chk("both_cy", pair_cy, 1);

    // write_en vs add on the same pair, then on different pairs.
    a_sel = 4'd7; din = 8'hAA; write_en = 1'b1; b_sel = 4'd6; constant = 8'h05; pair_add = 1'b1;
    tick();
    chk("conf_lo", out_b, 8'h00); chk("conf_hi", out_c, 8'hAA); chk("conf_cy", pair_cy, 1);
    a_sel = 4'd1; din = 8'h11;
    tick(); write_en = 1'b0; pair_add = 1'b0;
    chk("both_wr", out_a, 8'h11); chk("both_plo", out_b, 8'h05); chk("both_phi", out_c, 8'hAA);
    chk("both_pcy", pair_cy, 0);

    // Move beats a simultaneous write.
    wr(4'd0, 8'hEF); wr(4'd1, 8'hBE);
    a_sel = 4'd0; b_sel = 4'd8; din = 8'h55; write_en = 1'b1; pair_move = 1'b1;
    tick(); write_en = 1'b0; pair_move = 1'b0;
    #1;
    chk("mv_lo", out_b, 8'hEF); chk("mv_hi", out_c, 8'hBE); chk("mv_r0", out_a, 8'hEF);

    // Context save, ack delays alternating 0 and 3.
    for (int n = 0; n < 16; n++) wr(4'(n), 8'(n + 1));
    ctx_save = 1'b1; tick(); ctx_save = 1'b0;
    chk("sv_busy", ctx_busy, 1);
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < ((i % 2 == 1) ? 3 : 0); d++) begin
        chk("sv_hold_req", mem_if.mem_req, 1); chk("sv_hold_addr", mem_if.mem_addr, i);
        tick();
      end
      chk("sv_req", mem_if.mem_req, 1); chk("sv_we", mem_if.mem_we, 1);
      chk("sv_addr", mem_if.mem_addr, i); chk("sv_wdata", mem_if.mem_wdata, i + 1);
      chk("sv_nodone", ctx_done, 0);
      mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    end
    chk("sv_done", ctx_done, 1); chk("sv_idle", ctx_busy, 0); chk("sv_req_off", mem_if.mem_req, 0);
    tick();
    chk("sv_done_pulse", ctx_done, 0);

    // Context restore with writes/pair ops attempted while busy.
    ctx_restore = 1'b1; tick(); ctx_restore = 1'b0;
    a_sel = 4'd5; din = 8'h33; write_en = 1'b1; b_sel = 4'd2; constant = 8'h01; pair_add = 1'b1;
    ctx_save = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < ((i % 2 == 1) ? 2 : 0); d++) tick();
      chk("rs_req", mem_if.mem_req, 1); chk("rs_we", mem_if.mem_we, 0);
      chk("rs_addr", mem_if.mem_addr, i);
      mem_if.mem_rdata = 8'(8'hF0 + i); mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
      if (i == 15) begin
        write_en = 1'b0; pair_add = 1'b0; ctx_save = 1'b0;
      end
    end
    chk("rs_done", ctx_done, 1); chk("rs_idle", ctx_busy, 0);
    for (int n = 0; n < 16; n++) begin
      a_sel = 4'(n); #1;
      chk("rs_rf", out_a, 8'hF0 + n);
    end
    tick();
    chk("rs_still_idle", ctx_busy, 0);

    // Reset in the middle of a restore.
    ctx_restore = 1'b1; tick(); ctx_restore = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_rdata = 8'h5A; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    end
    chk("ab_idx", mem_if.mem_addr, 5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("ab_req", mem_if.mem_req, 0); chk("ab_busy", ctx_busy, 0); chk("ab_done", ctx_done, 0);
    for (int n = 0; n < 16; n++) begin
      a_sel = 4'(n); #1;
      chk("ab_rf", out_a, 0);
    end
    tick();
    chk("ab_nodone", ctx_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
